// File: rtl/waterlight_pkg.sv
// Shared definitions for the WaterLight AHB-Lite control slave:
// register offsets, CTRL bit positions, mode and apply-state encodings.
package waterlight_pkg;

    localparam logic [1:0] ADDR_MODE  = 2'd0;
    localparam logic [1:0] ADDR_SPEED = 2'd1;
    localparam logic [1:0] ADDR_TICKS = 2'd2;
    localparam logic [1:0] ADDR_CTRL  = 2'd3;

    localparam int CTRL_SYNC_EN = 0;
    localparam int CTRL_PEND    = 8;

    typedef enum logic [1:0] {
        MODE_OFF = 2'b00,
        MODE_M1  = 2'b01,
        MODE_M2  = 2'b10,
        MODE_M3  = 2'b11
    } wl_mode_e;

    typedef enum logic {
        AP_IDLE = 1'b0,
        AP_PEND = 1'b1
    } apply_st_e;

    function automatic logic [31:0] ctrl_word(
        input logic sync_en,
        input logic pend
    );
        logic [31:0] w;
        w = '0;
        w[CTRL_SYNC_EN] = sync_en;
        w[CTRL_PEND]    = pend;
        return w;
    endfunction

endpackage

// File: rtl/ahblite_waterlight_ctrl_if.sv
// AHB-Lite bus bundle between the Cortex-M0 fabric and the WaterLight slave.
// Ports: HSEL/HADDR/HTRANS/HSIZE/HPROT/HWRITE/HWDATA/HREADY in, HREADYOUT/HRESP/HRDATA out.
interface ahblite_waterlight_ctrl_if;

    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [3:0]  HPROT;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HSIZE, HPROT,
        output HWRITE, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HSIZE, HPROT,
        input  HWRITE, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );

endinterface

// File: rtl/waterlight_tick_cnt.sv
// LEDclk rising-edge detector and 32-bit wrapping TICKS counter.
// Ports: clk, RSTn, LEDclk, clr in; rise (1-cycle pulse), ticks out.
module waterlight_tick_cnt (
    input  logic        clk,
    input  logic        RSTn,
    input  logic        LEDclk,
    input  logic        clr,
    output logic        rise,
    output logic [31:0] ticks
);

    logic        led_d;
    logic [31:0] cnt_q;

    assign rise  = LEDclk & ~led_d;
    assign ticks = cnt_q;

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            led_d <= 1'b0;
        end else begin
            led_d <= LEDclk;
        end
    end

    // Clear wins over a coincident rise.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (rise) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

endmodule

// File: rtl/ahblite_waterlight_ctrl.sv
// AHB-Lite slave holding WaterLight MODE/SPEED with optional LEDclk-synced apply.
// Ports: clk, RSTn, bus (AHB slave), LEDclk in; WaterLight_mode, WaterLight_speed out.
module ahblite_waterlight_ctrl #(
    parameter logic [31:0] SPEED_RST = 32'd5_000_000,
    parameter logic [1:0]  MODE_RST  = 2'b00
) (
    input  logic                       clk,
    input  logic                       RSTn,
    ahblite_waterlight_ctrl_if.slave   bus,
    input  logic                       LEDclk,
    output logic [1:0]                 WaterLight_mode,
    output logic [31:0]                WaterLight_speed
);

    import waterlight_pkg::*;

    logic        accept;
    logic        wr_en;
    logic        rd_en;
    logic [1:0]  addr_q;

    logic        wr_mode;
    logic        wr_speed;
    logic        wr_ticks;
    logic        wr_ctrl;

    logic [1:0]  mode_q;
    logic [1:0]  mode_d;
    logic [31:0] speed_q;
    logic [31:0] speed_d;
    logic        sync_q;
    logic        sync_d;
    logic [1:0]  wl_mode_d;
    logic [31:0] wl_speed_d;
    apply_st_e   st_q;
    apply_st_e   st_d;

    logic        rise;
    logic [31:0] ticks;
    logic [31:0] rdata;
    logic        unused_bus;

    assign unused_bus = ^{bus.HSIZE, bus.HPROT, bus.HTRANS[0],
                          bus.HADDR[31:4], bus.HADDR[1:0]};

    assign accept = bus.HSEL & bus.HTRANS[1] & bus.HREADY;

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            wr_en  <= 1'b0;
            rd_en  <= 1'b0;
            addr_q <= '0;
        end else begin
            wr_en  <= accept & bus.HWRITE;
            rd_en  <= accept & ~bus.HWRITE;
            if (accept) begin
                addr_q <= bus.HADDR[3:2];
            end
        end
    end

    assign wr_mode  = wr_en & (addr_q == ADDR_MODE);
    assign wr_speed = wr_en & (addr_q == ADDR_SPEED);
    assign wr_ticks = wr_en & (addr_q == ADDR_TICKS);
    assign wr_ctrl  = wr_en & (addr_q == ADDR_CTRL);

    waterlight_tick_cnt u_tick (
        .clk    (clk),
        .RSTn   (RSTn),
        .LEDclk (LEDclk),
        .clr    (wr_ticks),
        .rise   (rise),
        .ticks  (ticks)
    );

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            mode_q           <= MODE_RST;
            speed_q          <= SPEED_RST;
            sync_q           <= 1'b0;
            st_q             <= AP_IDLE;
            WaterLight_mode  <= MODE_RST;
            WaterLight_speed <= SPEED_RST;
        end else begin
            mode_q           <= mode_d;
            speed_q          <= speed_d;
            sync_q           <= sync_d;
            st_q             <= st_d;
            WaterLight_mode  <= wl_mode_d;
            WaterLight_speed <= wl_speed_d;
        end
    end

    // A rise applies the staged values as they were before this
    // cycle's write; a coincident MODE/SPEED write keeps the update
    // pending for the following rise.
    always_comb begin
        mode_d     = mode_q;
        speed_d    = speed_q;
        sync_d     = sync_q;
        st_d       = st_q;
        wl_mode_d  = WaterLight_mode;
        wl_speed_d = WaterLight_speed;

        if (wr_mode)  mode_d  = bus.HWDATA[1:0];
        if (wr_speed) speed_d = bus.HWDATA;
        if (wr_ctrl)  sync_d  = bus.HWDATA[CTRL_SYNC_EN];

        unique case (st_q)
            AP_IDLE: begin
                if (sync_q) begin
                    if (wr_mode || wr_speed) st_d = AP_PEND;
                end else begin
                    if (wr_mode)  wl_mode_d  = bus.HWDATA[1:0];
                    if (wr_speed) wl_speed_d = bus.HWDATA;
                end
            end
            AP_PEND: begin
                if (rise ||
                    (wr_ctrl && !bus.HWDATA[CTRL_SYNC_EN])) begin
                    wl_mode_d  = mode_q;
                    wl_speed_d = speed_q;
                    st_d = (wr_mode || wr_speed) ? AP_PEND : AP_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        rdata = '0;
        if (rd_en) begin
            unique case (addr_q)
                ADDR_MODE:  rdata = {30'd0, mode_q};
                ADDR_SPEED: rdata = speed_q;
                ADDR_TICKS: rdata = ticks;
                ADDR_CTRL:  rdata = ctrl_word(sync_q, st_q == AP_PEND);
            endcase
        end
    end

    assign bus.HRDATA    = rdata;
    assign bus.HREADYOUT = 1'b1;
    assign bus.HRESP     = 1'b0;

endmodule

// File: tb/tb_ahblite_waterlight_ctrl.sv
// Directed bench for ahblite_waterlight_ctrl with a read-data scoreboard.
// Ports: none; drives the AHB interface, LEDclk and RSTn.
module tb_ahblite_waterlight_ctrl;

    localparam logic [31:0] SPD_RST = 32'd5_000_000;

    logic        clk;
    logic        RSTn;
    logic        LEDclk;
    logic [1:0]  wl_mode;
    logic [31:0] wl_speed;

    int n_chk;
    int n_pass;
    logic [31:0] exp_q[$];

    ahblite_waterlight_ctrl_if bus ();

    ahblite_waterlight_ctrl #(
        .SPEED_RST (SPD_RST),
        .MODE_RST  (2'b00)
    ) dut (
        .clk              (clk),
        .RSTn             (RSTn),
        .bus              (bus),
        .LEDclk           (LEDclk),
        .WaterLight_mode  (wl_mode),
        .WaterLight_speed (wl_speed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    endtask

    task automatic idle();
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        bus.HWRITE = 1'b0;
    endtask

    task automatic pop_chk(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            n_chk++;
            $error("FAIL %s: got empty queue want entry", tag);
        end else begin
            e = exp_q.pop_front();
            check(tag, bus.HRDATA, e);
        end
    endtask

    task automatic wr(input logic [31:0] a,
                      input logic [31:0] d,
                      input logic led);
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'b10;
        bus.HWRITE = 1'b1;
        bus.HADDR  = a;
        @(negedge clk);
        idle();
        bus.HWDATA = d;
        LEDclk     = led;
        @(negedge clk);
        LEDclk = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a,
                      input logic [31:0] e,
                      input string tag);
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'b10;
        bus.HWRITE = 1'b0;
        bus.HADDR  = a;
        exp_q.push_back(e);
        @(negedge clk);
        idle();
        pop_chk(tag);
    endtask

    task automatic pulse();
        LEDclk = 1'b1;
        @(negedge clk);
        LEDclk = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        n_chk      = 0;
        n_pass     = 0;
        RSTn       = 1'b0;
        LEDclk     = 1'b0;
        bus.HADDR  = '0;
        bus.HWDATA = '0;
        bus.HSIZE  = 3'b010;
        bus.HPROT  = 4'b0011;
        bus.HREADY = 1'b1;
        idle();
        repeat (3) @(negedge clk);
        RSTn = 1'b1;
        @(negedge clk);

        // T1 reset state
        check("rst_mode", {30'd0, wl_mode}, 32'd0);
        check("rst_speed", wl_speed, SPD_RST);
        check("rst_hreadyout", {31'd0, bus.HREADYOUT}, 32'd1);
        check("rst_hresp", {31'd0, bus.HRESP}, 32'd0);
        check("rst_hrdata_idle", bus.HRDATA, 32'd0);
        rd(32'hC, 32'h0, "rst_ctrl");
        rd(32'h4, SPD_RST, "rst_speed_reg");
        rd(32'h8, 32'h0, "rst_ticks");

        // T2 direct apply
        wr(32'h0, 32'hFFFF_FFFF, 1'b0);
        check("t2_mode_out", {30'd0, wl_mode}, 32'd3);
        rd(32'h0, 32'h3, "t2_mode_rd");

        // T3 synced apply
        wr(32'hC, 32'h1, 1'b0);
        rd(32'hC, 32'h1, "t3_ctrl_en");
        wr(32'h4, 32'd10, 1'b0);
        wr(32'h0, 32'h1, 1'b0);
        check("t3_mode_hold", {30'd0, wl_mode}, 32'd3);
        check("t3_speed_hold", wl_speed, SPD_RST);
        rd(32'hC, 32'h101, "t3_ctrl_pend");
        pulse();
        check("t3_mode_apply", {30'd0, wl_mode}, 32'd1);
        check("t3_speed_apply", wl_speed, 32'd10);
        rd(32'hC, 32'h001, "t3_ctrl_clr");
        rd(32'h8, 32'd1, "t3_ticks");

        // T4 write coincident with a rise
        wr(32'h0, 32'h3, 1'b0);
        check("t4_hold", {30'd0, wl_mode}, 32'd1);
        wr(32'h0, 32'h2, 1'b1);
        check("t4_old_applied", {30'd0, wl_mode}, 32'd3);
        rd(32'hC, 32'h101, "t4_still_pend");
        pulse();
        check("t4_new_applied", {30'd0, wl_mode}, 32'd2);
        rd(32'hC, 32'h001, "t4_pend_clr");
        rd(32'h8, 32'd3, "t4_ticks");
        wr(32'h0, 32'h0, 1'b0);
        check("t4_pend_hold", {30'd0, wl_mode}, 32'd2);
        wr(32'hC, 32'h0, 1'b0);
        check("t4_sync_off_apply", {30'd0, wl_mode}, 32'd0);
        rd(32'hC, 32'h0, "t4_ctrl_off");

        // T5 back-to-back write then read, then no-write cycles
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'b10;
        bus.HWRITE = 1'b1;
        bus.HADDR  = 32'h4;
        @(negedge clk);
        bus.HWDATA = 32'h1234;
        bus.HWRITE = 1'b0;
        exp_q.push_back(32'h1234);
        @(negedge clk);
        idle();
        check("t5_speed_out", wl_speed, 32'h1234);
        pop_chk("t5_b2b_rd");
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'b00;
        bus.HWRITE = 1'b1;
        bus.HADDR  = 32'h4;
        @(negedge clk);
        bus.HWDATA = 32'hDEAD;
        bus.HTRANS = 2'b01;
        @(negedge clk);
        bus.HWDATA = 32'hBEEF;
        bus.HTRANS = 2'b10;
        bus.HREADY = 1'b0;
        @(negedge clk);
        bus.HREADY = 1'b1;
        idle();
        bus.HWDATA = 32'hCAFE;
        @(negedge clk);
        rd(32'h4, 32'h1234, "t5_idle_nowr");
        check("t5_speed_keep", wl_speed, 32'h1234);

        // T6 ticks wrap, clear vs rise, reset while pending
        force dut.u_tick.cnt_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.u_tick.cnt_q;
        pulse();
        rd(32'h8, 32'h0, "t6_wrap");
        pulse();
        pulse();
        pulse();
        rd(32'h8, 32'd3, "t6_count");
        wr(32'h8, 32'h0, 1'b1);
        rd(32'h8, 32'h0, "t6_clr_vs_rise");
        wr(32'hC, 32'h1, 1'b0);
        wr(32'h0, 32'h2, 1'b0);
        rd(32'hC, 32'h101, "t6_pend_set");
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'b10;
        bus.HWRITE = 1'b1;
        bus.HADDR  = 32'h4;
        @(negedge clk);
        idle();
        bus.HWDATA = 32'h55;
        RSTn = 1'b0;
        #1;
        check("t6_async_speed", wl_speed, SPD_RST);
        @(negedge clk);
        RSTn = 1'b1;
        @(negedge clk);
        check("t6_rst_mode", {30'd0, wl_mode}, 32'd0);
        rd(32'hC, 32'h0, "t6_rst_ctrl");
        rd(32'h4, SPD_RST, "t6_lost_write");
        rd(32'h0, 32'h0, "t6_rst_mode_reg");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
